branch_predict_unit: RTL and testbench

Parametrised branch resolution and prediction block for the pipelined MIPS core. It replaces the single-cycle three-type branch comparator.
- Resolves an extended set of compare conditions on WIDTH-bit operands in D.
- Holds a BHT_DEPTH-entry table of 2-bit saturating counters, read in F and trained in D.
- Flags mispredictions and keeps saturating branch/mispredict statistics counters.

---
 rtl/branch_predict_unit_pkg.sv | 34 +++
 rtl/branch_predict_unit_if.sv | 30 +++
 rtl/branch_predict_unit_branch_cmp.sv | 27 ++
 rtl/branch_predict_unit.sv | 79 +++++++
 tb/tb_branch_predict_unit.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings for the branch predict unit: condition codes and
// 2-bit saturating counter states plus the counter step helper.
package branch_predict_unit_pkg;

  typedef enum logic [3:0] {
    BR_NONE = 4'b0000,
    BR_BEQ  = 4'b0001,
    BR_SLT  = 4'b0010,
    BR_BNE  = 4'b0011,
    BR_BLEZ = 4'b0100,
    BR_BGT  = 4'b0101,
    BR_BGE  = 4'b0110,
    BR_SLTU = 4'b1000
  } br_type_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
    logic [1:0] n;
    n = c;
    if (up) begin
      if (c != ST) n = c + 2'd1;
    end else begin
      if (c != SNT) n = c - 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch lookup, D-stage resolve and statistics signals of the branch predict unit.
interface branch_predict_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) ();
  logic [PC_W-1:0]  pc_f;
  logic             pred_taken_f;
  logic             res_valid;
  logic [PC_W-1:0]  res_pc;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       Type;
  logic             res_pred_taken;
  logic             taken;
  logic             mispredict;
  logic             stat_clr;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output pc_f, res_valid, res_pc, A, B, Type, res_pred_taken, stat_clr,
    input  pred_taken_f, taken, mispredict, branch_cnt, mispred_cnt
  );

  modport slave (
    input  pc_f, res_valid, res_pc, A, B, Type, res_pred_taken, stat_clr,
    output pred_taken_f, taken, mispredict, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predict_unit_branch_cmp.sv
// Combinational branch condition resolver; unknown codes are non-branches.
module branch_cmp
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       br_type,
  output logic             taken,
  output logic             is_branch
);
  always_comb begin
    taken     = 1'b0;
    is_branch = 1'b1;
    case (br_type)
      BR_BEQ:  taken = (a == b);
      BR_SLT:  taken = ($signed(a) <  $signed(b));
      BR_BLEZ: taken = ($signed(a) <= $signed(b));
      BR_BNE:  taken = (a != b);
      BR_BGT:  taken = ($signed(a) >  $signed(b));
      BR_BGE:  taken = ($signed(a) >= $signed(b));
      BR_SLTU: taken = (a < b);
      default: is_branch = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: BHT of 2-bit counters read in F, trained in D,
// with misprediction flag and saturating branch/mispredict statistics.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned CNT_W     = 16
) (
  input logic clk,
  input logic reset,
  branch_predict_unit_if.slave bus
);
  localparam int unsigned IDX = $clog2(BHT_DEPTH);

  if (BHT_DEPTH < 2 || (1 << IDX) != BHT_DEPTH) begin : g_bad_depth
    $error("BHT_DEPTH must be a power of 2 and at least 2");
  end
  if (PC_W < IDX + 2) begin : g_bad_pc_w
    $error("PC_W too narrow for the BHT index");
  end

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d [BHT_DEPTH];
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic [IDX-1:0]   idx_f, idx_r;
  logic             taken, is_branch, upd, mispredict;

  branch_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a         (bus.A),
    .b         (bus.B),
    .br_type   (bus.Type),
    .taken     (taken),
    .is_branch (is_branch)
  );

  assign idx_f      = bus.pc_f[IDX+1:2];
  assign idx_r      = bus.res_pc[IDX+1:2];
  assign upd        = bus.res_valid & is_branch;
  assign mispredict = upd & (taken != bus.res_pred_taken);

  // Lookup reads the registered table only, so a same-cycle update is not seen.
  assign bus.pred_taken_f = bht_q[idx_f][1];
  assign bus.taken        = taken;
  assign bus.mispredict   = mispredict;
  assign bus.branch_cnt   = branch_cnt_q;
  assign bus.mispred_cnt  = mispred_cnt_q;

  always_comb begin
    bht_d = bht_q;
    if (upd) bht_d[idx_r] = ctr_next(bht_q[idx_r], taken);
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (bus.stat_clr) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else begin
      if (upd && branch_cnt_q != '1)         branch_cnt_d  = branch_cnt_q + CNT_W'(1);
      if (mispredict && mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) bht_q[i] <= WNT;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      bht_q         <= bht_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed scenarios plus random
// traffic, checked against a behavioural model of the predictor and counters.
module tb_branch_predict_unit;
  localparam int unsigned DEPTH = 16;
  localparam int          CMAX  = 15;   // CNT_W = 4

  typedef struct {
    bit taken;
    bit misp;
    bit pred;
    int bc;
    int mc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.WIDTH(32), .PC_W(32), .CNT_W(4)) bus ();

  branch_predict_unit #(.WIDTH(32), .PC_W(32), .BHT_DEPTH(DEPTH), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_bht [DEPTH];
  int   m_bc, m_mc;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_is_br(input logic [3:0] t);
    return t inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8};
  endfunction

  function automatic bit ref_taken(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (t)
      4'd1: return sa == sb;
      4'd2: return sa < sb;
      4'd4: return sa <= sb;
      4'd3: return sa != sb;
      4'd5: return sa > sb;
      4'd6: return sa >= sb;
      4'd8: return ua < ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
    m_bc = 0;
    m_mc = 0;
  endtask

  // One cycle: drive just after the rising edge, queue what must be seen
  // before the next edge, then advance the model across that edge.
  task automatic step(input bit rst, input logic [31:0] pcf, input bit v,
                      input logic [31:0] rpc, input logic [3:0] t,
                      input logic [31:0] a, input logic [31:0] b,
                      input bit rp, input bit clr);
    exp_t e;
    bit   br, tk;
    @(posedge clk);
    #1;
    reset              = rst;
    bus.pc_f           = pcf;
    bus.res_valid      = v;
    bus.res_pc         = rpc;
    bus.Type           = t;
    bus.A              = a;
    bus.B              = b;
    bus.res_pred_taken = rp;
    bus.stat_clr       = clr;
    if (rst) model_reset();
    br      = v && ref_is_br(t);
    tk      = ref_taken(t, a, b);
    e.taken = tk;
    e.misp  = br && (tk != rp);
    e.pred  = m_bht[slot(pcf)] >= 2;
    e.bc    = m_bc;
    e.mc    = m_mc;
    q.push_back(e);
    if (!rst) begin
      if (clr) begin
        m_bc = 0;
        m_mc = 0;
      end else begin
        if (br && m_bc < CMAX) m_bc++;
        if (e.misp && m_mc < CMAX) m_mc++;
      end
      if (br) begin
        if (tk) m_bht[slot(rpc)] = (m_bht[slot(rpc)] == 3) ? 3 : m_bht[slot(rpc)] + 1;
        else    m_bht[slot(rpc)] = (m_bht[slot(rpc)] == 0) ? 0 : m_bht[slot(rpc)] - 1;
      end
    end
  endtask

  task automatic idle(input logic [31:0] pcf);
    step(1'b0, pcf, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("taken",        int'(bus.taken),        int'(e.taken));
        check("mispredict",   int'(bus.mispredict),   int'(e.misp));
        check("pred_taken_f", int'(bus.pred_taken_f), int'(e.pred));
        check("branch_cnt",   int'(bus.branch_cnt),   e.bc);
        check("mispred_cnt",  int'(bus.mispred_cnt),  e.mc);
      end
    end
  end

  initial begin : stim
    logic [3:0]  sweep [8];
    logic [31:0] a, b, rpc, pcf;
    logic [3:0]  t;
    sweep = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'hF};
    bus.pc_f = '0; bus.res_valid = 1'b0; bus.res_pc = '0; bus.Type = '0;
    bus.A = '0; bus.B = '0; bus.res_pred_taken = 1'b0; bus.stat_clr = 1'b0;
    model_reset();

    step(1'b1, 32'h3000, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(32'h3000);
    idle(32'h3000);

    // beq taken twice while predicted not-taken: entry 1 walks 01->10->11
    repeat (2) step(1'b0, 32'h3004, 1'b1, 32'h3004, 4'd1, 32'd5, 32'd5, 1'b0, 1'b0);
    idle(32'h3004);

    // comparator sweep with A=-1, B=1, no training
    foreach (sweep[i]) step(1'b0, 32'h3000, 1'b0, 32'h0, sweep[i], 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    step(1'b0, 32'h3000, 1'b1, 32'h3000, 4'hF, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);

    // same-cycle read of the entry being trained sees the old value
    step(1'b0, 32'h3008, 1'b1, 32'h3008, 4'd1, 32'd7, 32'd7, 1'b0, 1'b0);
    idle(32'h3008);

    repeat (4) step(1'b0, 32'h300C, 1'b1, 32'h300C, 4'd1, 32'd1, 32'd2, 1'b1, 1'b0);
    idle(32'h300C);

    repeat (20) step(1'b0, 32'h3010, 1'b1, 32'h3010, 4'd3, 32'd1, 32'd2, 1'b0, 1'b0);
    step(1'b0, 32'h3010, 1'b1, 32'h3010, 4'd3, 32'd1, 32'd2, 1'b0, 1'b1);
    idle(32'h3010);

    // train, then reset with an update pending on the edge
    repeat (2) step(1'b0, 32'h3014, 1'b1, 32'h3014, 4'd2, 32'd1, 32'd9, 1'b0, 1'b0);
    step(1'b1, 32'h3014, 1'b1, 32'h3014, 4'd2, 32'd1, 32'd9, 1'b0, 1'b0);
    idle(32'h3014);

    repeat (600) begin
      rpc = 32'h3000 + ($urandom_range(0, 31) << 2);
      pcf = ($urandom_range(0, 3) == 0) ? rpc : 32'h3000 + ($urandom_range(0, 31) << 2);
      t   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : sweep[$urandom_range(0, 6)];
      a   = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 4)) - 32'd2;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 32'($urandom_range(0, 4)) - 32'd2;
        default: b = $urandom;
      endcase
      step($urandom_range(0, 149) == 0, pcf, $urandom_range(0, 4) != 0, rpc, t, a, b,
           1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
    end

    idle(32'h3000);
    repeat (3) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
